// File: rtl/async_wr_ctrl_ps.sv
// Purpose: write-side controller of an async FIFO (binary/Gray write pointer, rd pointer sync, flags).
// Latency: accepted write updates wr_cnt/wr_full/wr_ptr_gray at the same edge; rd pointer moves
//          reach the flags SYNC_STAGES+1 edges after capture.
// Backpressure: wr_full rejects writes; a write while full in RUN sets the sticky overflow flag.
//
// Ports:
//   wr_clk, rst_n             write-domain clock, asynchronous active-low reset
//   wr_en                     write request (one entry per cycle)
//   rd_ptr_gray               read pointer (Gray) from the read domain, asynchronous
//   afull_thresh, clr_ovf     almost-full level (quasi-static), overflow clear
//   wr_addr, wr_ptr_gray      RAM write address, registered Gray write pointer
//   wr_full, wr_afull         full / almost-full flags
//   wr_cnt, wr_free           occupancy and free space seen from the write side
//   overflow                  sticky write-while-full indication
module async_wr_ctrl_ps #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          wr_clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   rd_ptr_gray,
  input  logic [AW:0]   afull_thresh,
  input  logic          clr_ovf,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_ptr_gray,
  output logic          wr_full,
  output logic          wr_afull,
  output logic [AW:0]   wr_cnt,
  output logic [AW:0]   wr_free,
  output logic          overflow
);

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("async_wr_ctrl_ps: DEPTH must be a power of two and >= 4");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("async_wr_ctrl_ps: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [2:0]  INIT_LAST = 3'(SYNC_STAGES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  init_cnt_q, init_cnt_d;
  logic [AW:0] wr_bin_q, wr_bin_d;
  logic [AW:0] sync_q [SYNC_STAGES];
  logic [AW:0] rd_bin;
  logic [AW:0] cnt_next;
  logic        accept;
  logic        ovf_set;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Read pointer synchroniser; only Gray values cross, so at most one bit is in flight.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rd_bin = gray2bin(sync_q[SYNC_STAGES-1]);

  // INIT holds the flags closed until the synchroniser has flushed its reset contents.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    accept     = 1'b0;
    ovf_set    = 1'b0;
    wr_bin_d   = wr_bin_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 3'd1;
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        accept  = wr_en & ~wr_full;
        ovf_set = wr_en & wr_full;
      end
      default: state_d = ST_INIT;
    endcase
    if (accept) wr_bin_d = wr_bin_q + 1'b1;
  end

  // Occupancy uses the post-write pointer so full asserts on the edge that fills the FIFO.
  assign cnt_next = wr_bin_d - rd_bin;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q    <= '0;
      wr_ptr_gray <= '0;
      wr_cnt      <= '0;
      wr_free     <= '0;
      wr_full     <= 1'b1;
      wr_afull    <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      wr_ptr_gray <= bin2gray(wr_bin_d);
      // Set beats clear when both happen in the same cycle.
      overflow    <= ovf_set | (overflow & ~clr_ovf);
      if (state_q == ST_RUN) begin
        wr_cnt   <= cnt_next;
        wr_free  <= DEPTH_W - cnt_next;
        wr_full  <= (cnt_next == DEPTH_W);
        wr_afull <= (cnt_next >= afull_thresh);
      end else begin
        wr_free  <= '0;
        wr_full  <= 1'b1;
        wr_afull <= 1'b1;
      end
    end
  end

  assign wr_addr = wr_bin_q[AW-1:0];

endmodule

// File: tb/tb_async_wr_ctrl_ps.sv
// Purpose: directed self-checking bench for async_wr_ctrl_ps with DEPTH=8, SYNC_STAGES=2.
// Latency: inputs driven and outputs sampled 1 time unit after each rising wr_clk edge.
// Backpressure: exercises full, overflow set/clear and read-pointer driven release.
module tb_async_wr_ctrl_ps;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          wr_clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   afull_thresh;
  logic          clr_ovf;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          wr_full;
  logic          wr_afull;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   wr_free;
  logic          overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  async_wr_ctrl_ps #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_ptr_gray  (rd_ptr_gray),
    .afull_thresh (afull_thresh),
    .clr_ovf      (clr_ovf),
    .wr_addr      (wr_addr),
    .wr_ptr_gray  (wr_ptr_gray),
    .wr_full      (wr_full),
    .wr_afull     (wr_afull),
    .wr_cnt       (wr_cnt),
    .wr_free      (wr_free),
    .overflow     (overflow)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(wr_addr),     32'h0);
    chk({tag, "_gray"},  32'(wr_ptr_gray), 32'h0);
    chk({tag, "_cnt"},   32'(wr_cnt),      32'h0);
    chk({tag, "_ovf"},   32'(overflow),    32'h0);
    chk({tag, "_full"},  32'(wr_full),     32'h1);
    chk({tag, "_afull"}, 32'(wr_afull),    32'h1);
    chk({tag, "_free"},  32'(wr_free),     32'h0);
  endtask

  initial begin
    logic [AW:0] wexp;
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    rd_ptr_gray  = '0;
    afull_thresh = 4'd6;
    clr_ovf      = 1'b0;

    // 1. reset values, INIT lasts three edges, INIT writes are dropped silently
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    wr_en = 1'b1;
    tick();
    chk("init1_full",  32'(wr_full),  32'h1);
    chk("init1_free",  32'(wr_free),  32'h0);
    tick();
    chk("init2_full",  32'(wr_full),  32'h1);
    chk("init2_afull", 32'(wr_afull), 32'h1);
    tick();
    chk("init3_full",  32'(wr_full),     32'h1);
    chk("init3_ovf",   32'(overflow),    32'h0);
    chk("init3_gray",  32'(wr_ptr_gray), 32'h0);
    wr_en = 1'b0;
    tick();
    chk("run_full",  32'(wr_full),  32'h0);
    chk("run_free",  32'(wr_free),  32'h8);
    chk("run_cnt",   32'(wr_cnt),   32'h0);
    chk("run_afull", 32'(wr_afull), 32'h0);

    // 2. eight back-to-back writes fill the FIFO
    for (int j = 1; j <= 8; j++) begin
      chk("fill_addr", 32'(wr_addr), 32'(j - 1));
      wr_en = 1'b1;
      tick();
      chk("fill_gray",  32'(wr_ptr_gray), 32'(gray(4'(j))));
      chk("fill_cnt",   32'(wr_cnt),      32'(j));
      chk("fill_afull", 32'(wr_afull),    32'(j >= 6));
      chk("fill_full",  32'(wr_full),     32'(j == 8));
    end
    chk("fill_gray_c", 32'(wr_ptr_gray), 32'hC);

    // 3. write while full sets overflow; set beats clear; clear alone wins
    tick();
    chk("ovf_gray", 32'(wr_ptr_gray), 32'hC);
    chk("ovf_set",  32'(overflow),    32'h1);
    chk("ovf_cnt",  32'(wr_cnt),      32'h8);
    clr_ovf = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'h1);
    wr_en = 1'b0;
    tick();
    chk("ovf_clr", 32'(overflow), 32'h0);
    clr_ovf = 1'b0;

    // 4. read pointer to 2 frees two entries after three edges
    rd_ptr_gray = 4'b0011;
    tick();
    chk("rd_e1_full", 32'(wr_full), 32'h1);
    tick();
    chk("rd_e2_full", 32'(wr_full), 32'h1);
    tick();
    chk("rd_e3_full", 32'(wr_full), 32'h0);
    chk("rd_e3_free", 32'(wr_free), 32'h2);
    chk("rd_e3_cnt",  32'(wr_cnt),  32'h6);
    wr_en = 1'b1;
    tick();
    chk("rd_wr_cnt",  32'(wr_cnt),      32'h7);
    chk("rd_wr_gray", 32'(wr_ptr_gray), 32'hD);
    wr_en = 1'b0;

    // 5. 20 writes with the synchronised read pointer kept 2 behind the write
    //    pointer; the read pointer is driven two edges ahead of the sync delay.
    rd_ptr_gray = gray(4'd7);
    tick();
    tick();
    tick();
    chk("trk_pre_cnt", 32'(wr_cnt), 32'h2);
    for (int s = -1; s <= 20; s++) begin
      rd_ptr_gray = gray(4'(9 + s));
      wr_en       = (s >= 1);
      wexp        = (s >= 1) ? 4'(9 + s) : 4'd9;
      tick();
      chk("trk_cnt",  32'(wr_cnt),      32'h2);
      chk("trk_full", 32'(wr_full),     32'h0);
      chk("trk_gray", 32'(wr_ptr_gray), 32'(gray(wexp)));
    end
    wr_en = 1'b0;

    // 6. asynchronous reset in the middle of a burst, then INIT again
    tick();
    tick();
    tick();
    wr_en = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    wr_en       = 1'b0;
    rd_ptr_gray = '0;
    @(posedge wr_clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("re1_full", 32'(wr_full), 32'h1);
    tick();
    chk("re2_full", 32'(wr_full), 32'h1);
    tick();
    chk("re3_full", 32'(wr_full), 32'h1);
    tick();
    chk("re4_full", 32'(wr_full),     32'h0);
    chk("re4_free", 32'(wr_free),     32'h8);
    chk("re4_gray", 32'(wr_ptr_gray), 32'h0);
    chk("re4_addr", 32'(wr_addr),     32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/async_wr_ctrl_ps.md
Name: async_wr_ctrl_ps

Overview:
Next-generation write-side controller for the async FIFO, one instance per FIFO write domain.
- Owns the write pointer (binary plus registered Gray) and synchronises the read-domain Gray pointer internally through SYNC_STAGES flops.
- Produces registered full, almost-full, occupancy and free-space outputs.
- Adds a power-up INIT phase, a programmable almost-full threshold and a sticky overflow flag with clear.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two and >= 4 (elaboration error otherwise); AW = $clog2(DEPTH).
SYNC_STAGES, 2, flops in the rd_ptr_gray synchroniser; legal range 2..4.

Ports:
wr_clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request, one entry per cycle
rd_ptr_gray  in  AW+1  read pointer in Gray code, from the read domain (asynchronous)
afull_thresh  in  AW+1  almost-full level, quasi-static
clr_ovf  in  1  clears overflow
wr_addr  out  AW  RAM write address (low AW bits of binary write pointer)
wr_ptr_gray  out  AW+1  registered Gray write pointer, to the read domain
wr_full  out  1  full / not ready
wr_afull  out  1  occupancy >= afull_thresh
wr_cnt  out  AW+1  occupancy seen from the write side, 0..DEPTH
wr_free  out  AW+1  DEPTH - wr_cnt, or 0 during INIT
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (rst_n low, asynchronous): all outputs take these values immediately.
  - wr_addr = 0, wr_ptr_gray = 0, wr_cnt = 0, overflow = 0.
  - wr_full = 1, wr_afull = 1, wr_free = 0.
  - Synchroniser flops = 0; FSM = INIT; INIT counter = 0.
- FSM has two states.
  - INIT: count wr_clk edges after rst_n rises. After SYNC_STAGES+1 edges, go to RUN.
  - In INIT, wr_full = 1, wr_afull = 1, wr_free = 0, and writes are rejected without setting overflow.
  - RUN: normal operation; RUN is left only through reset.
- Synchroniser: rd_ptr_gray -> SYNC_STAGES flops -> rd_sync. rd_bin = gray2bin(rd_sync), computed combinationally.
- Accept rule: accept = wr_en & ~wr_full & (state == RUN).
  - On accept, wr_bin advances by 1 modulo 2^(AW+1).
  - wr_ptr_gray <= bin2gray(wr_bin_next), driven from a flop, so only one bit changes per edge.
  - wr_addr = wr_bin[AW-1:0], so the address for the current write is valid in the same cycle as wr_en.
- Flags are computed at every edge in RUN from the next-state pointer and current rd_bin; there is no stale-full cycle after an accepted write.
  - cnt_next = wr_bin_next - rd_bin, mod 2^(AW+1).
  - wr_cnt <= cnt_next.
  - wr_free <= DEPTH - cnt_next.
  - wr_full <= (cnt_next == DEPTH).
  - wr_afull <= (cnt_next >= afull_thresh). afull_thresh = 0 gives wr_afull = 1 permanently; afull_thresh > DEPTH gives wr_afull = 0.
- Overflow: wr_en & wr_full in RUN sets overflow at the next edge. The pointer does not move.
  - clr_ovf clears overflow at the next edge.
  - Set wins when set and clr_ovf occur in the same cycle.
- Latency:
  - Accepted write -> wr_cnt / wr_full / wr_ptr_gray updated at the same edge.
  - Read pointer change -> wr_free / wr_full update SYNC_STAGES+1 edges after the first capture.
- Wrap-around: the pointer MSB toggles every DEPTH writes. Occupancy arithmetic must be correct across the 2^(AW+1) wrap.
- Reset mid-operation: the pointer returns to 0 asynchronously. The system must reset the read side together with the write side; this block does not check that.

Test Plan:
(All with DEPTH=8, SYNC_STAGES=2.)
1. Release rst_n with rd_ptr_gray=0 -> wr_full=1 for exactly 3 edges, then wr_full=0, wr_free=8, wr_cnt=0, wr_afull=0 (afull_thresh=6).
2. Eight back-to-back writes, rd_ptr_gray=0:
   - wr_addr steps 0..7.
   - wr_ptr_gray steps 0,1,3,2,6,7,5,4, then 0xC.
   - wr_afull rises at the edge accepting write 6.
   - wr_full=1 at the edge accepting write 8.
3. Ninth write while full -> wr_ptr_gray stays 0xC and overflow=1. Then clr_ovf with a simultaneous write -> overflow stays 1. clr_ovf alone -> overflow=0 next edge.
4. While full, drive rd_ptr_gray=4'b0011 (bin 2) -> wr_full falls and wr_free=2 on the third edge after the change; next write is accepted and wr_cnt=7.
5. Drive 20 writes while rd_ptr_gray tracks 2 entries behind (continuous read) -> pointer wraps through 4'b1000 to 0; wr_cnt stays 2 throughout; wr_full never asserts.
6. Assert rst_n low mid-burst, between clock edges -> all outputs reach their reset values immediately without a clock. After release, INIT lasts 3 edges again.
